// File: rtl/pipe_stage_skid_register.sv
// rtl/pipe_stage_skid_register.sv - parametrised pipeline stage register with 2-entry skid buffer
//
// Purpose:
//   Generic inter-stage register carrying a control bus and a data bus. It has a
//   valid bit per entry, turns held entries into bubbles on FLUSH, freezes under
//   BUSYWAIT, and uses a main + skid entry pair so that IN_READY is a flop output
//   with no combinational path from OUT_READY.
//
// Ports:
//   CLK        in   clock, rising edge
//   RESET      in   synchronous active-high reset
//   FLUSH      in   drop all held entries (the input offered in the same cycle is dropped too)
//   BUSYWAIT   in   global stall, freezes every register
//   IN_VALID   in   upstream entry present
//   IN_READY   out  stage can accept (registered)
//   IN_CTRL    in   upstream control  [CTRL_WIDTH]
//   IN_DATA    in   upstream payload  [DATA_WIDTH]
//   OUT_VALID  out  head entry valid
//   OUT_READY  in   downstream consumes head
//   OUT_CTRL   out  head control, BUBBLE_CTRL when not valid
//   OUT_DATA   out  head payload, holds its last value when not valid
//   OCCUPANCY  out  number of held entries (0..2)

module pipe_stage_skid_register #(
    parameter int                    DATA_WIDTH  = 64,
    parameter int                    CTRL_WIDTH  = 12,
    parameter logic [CTRL_WIDTH-1:0] BUBBLE_CTRL = {CTRL_WIDTH{1'b0}}
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  FLUSH,
    input  logic                  BUSYWAIT,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic [CTRL_WIDTH-1:0] IN_CTRL,
    input  logic [DATA_WIDTH-1:0] IN_DATA,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [CTRL_WIDTH-1:0] OUT_CTRL,
    output logic [DATA_WIDTH-1:0] OUT_DATA,
    output logic [1:0]            OCCUPANCY
);

    // Main entry drives the outputs; skid entry catches the one extra beat that
    // arrives while IN_READY (a flop) still advertises space.
    logic                  main_valid_q, main_valid_d;
    logic [CTRL_WIDTH-1:0] main_ctrl_q,  main_ctrl_d;
    logic [DATA_WIDTH-1:0] main_data_q,  main_data_d;
    logic                  skid_valid_q, skid_valid_d;
    logic [CTRL_WIDTH-1:0] skid_ctrl_q,  skid_ctrl_d;
    logic [DATA_WIDTH-1:0] skid_data_q,  skid_data_d;
    logic                  in_ready_q,   in_ready_d;

    logic accept;
    logic pop;

    assign accept = IN_VALID & in_ready_q & ~BUSYWAIT;
    assign pop    = main_valid_q & OUT_READY & ~BUSYWAIT;

    always_comb begin
        main_valid_d = main_valid_q;
        main_ctrl_d  = main_ctrl_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_data_d  = skid_data_q;

        if (FLUSH) begin
            // Payload registers keep their contents so OUT_DATA does not toggle.
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            // Full: IN_READY is low, so only a pop can change state.
            if (pop) begin
                main_valid_d = 1'b1;
                main_ctrl_d  = skid_ctrl_q;
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
                skid_ctrl_d  = '0;
                skid_data_d  = '0;
            end
        end else if (main_valid_q) begin
            if (pop && accept) begin
                main_ctrl_d = IN_CTRL;
                main_data_d = IN_DATA;
            end else if (pop) begin
                main_valid_d = 1'b0;
            end else if (accept) begin
                // Downstream did not take the head: park the new beat in the skid.
                skid_valid_d = 1'b1;
                skid_ctrl_d  = IN_CTRL;
                skid_data_d  = IN_DATA;
            end
        end else if (accept) begin
            main_valid_d = 1'b1;
            main_ctrl_d  = IN_CTRL;
            main_data_d  = IN_DATA;
        end

        // Ready for the next cycle is simply "skid will be free"; under BUSYWAIT
        // the skid holds, so this holds as well.
        in_ready_d = ~skid_valid_d;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            main_valid_q <= 1'b0;
            main_ctrl_q  <= BUBBLE_CTRL;
            main_data_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_ctrl_q  <= '0;
            skid_data_q  <= '0;
            in_ready_q   <= 1'b1;
        end else begin
            main_valid_q <= main_valid_d;
            main_ctrl_q  <= main_ctrl_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_data_q  <= skid_data_d;
            in_ready_q   <= in_ready_d;
        end
    end

    // Bubble control keeps downstream write/memory enables inactive whenever
    // the head is empty, regardless of what the control register still holds.
    assign OUT_VALID = main_valid_q;
    assign OUT_CTRL  = main_valid_q ? main_ctrl_q : BUBBLE_CTRL;
    assign OUT_DATA  = main_data_q;
    assign IN_READY  = in_ready_q;
    assign OCCUPANCY = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

endmodule

// File: tb/tb_pipe_stage_skid_register.sv
// tb/tb_pipe_stage_skid_register.sv - scoreboard testbench for pipe_stage_skid_register

module tb_pipe_stage_skid_register;

    localparam int DW = 64;
    localparam int CW = 12;

    logic          CLK = 1'b0;
    logic          RESET, FLUSH, BUSYWAIT;
    logic          IN_VALID, IN_READY, OUT_VALID, OUT_READY;
    logic [CW-1:0] IN_CTRL, OUT_CTRL;
    logic [DW-1:0] IN_DATA, OUT_DATA;
    logic [1:0]    OCCUPANCY;

    int checks = 0;
    int fails  = 0;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } item_t;

    item_t sb[$];
    item_t mon_e;

    pipe_stage_skid_register #(
        .DATA_WIDTH (DW),
        .CTRL_WIDTH (CW)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .FLUSH     (FLUSH),
        .BUSYWAIT  (BUSYWAIT),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .IN_CTRL   (IN_CTRL),
        .IN_DATA   (IN_DATA),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_CTRL  (OUT_CTRL),
        .OUT_DATA  (OUT_DATA),
        .OCCUPANCY (OCCUPANCY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d);
        IN_VALID = v;
        IN_DATA  = d;
        IN_CTRL  = 12'h100 | 12'(d[7:0]);
    endtask

    // Queue an entry the stage is expected to deliver, in delivery order.
    task automatic expect_item(input logic [DW-1:0] d);
        item_t e;
        e.d = d;
        e.c = 12'h100 | 12'(d[7:0]);
        sb.push_back(e);
    endtask

    task automatic status(input string name, input logic ov, input logic ir, input logic [1:0] occ);
        chk({name, "_out_valid"}, 64'(OUT_VALID), 64'(ov));
        chk({name, "_in_ready"},  64'(IN_READY),  64'(ir));
        chk({name, "_occupancy"}, 64'(OCCUPANCY), 64'(occ));
    endtask

    // Monitor: a transfer happens at the next rising edge whenever the head is
    // valid, downstream is ready and nothing overrides the handshake.
    always @(negedge CLK) begin
        if (!RESET) begin
            if (!OUT_VALID)
                chk("bubble_ctrl", 64'(OUT_CTRL), 64'h0);
            if (OUT_VALID && OUT_READY && !BUSYWAIT && !FLUSH) begin
                if (sb.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL sb_unexpected: got data %0h expected no output at %0t", OUT_DATA, $time);
                end else begin
                    mon_e = sb.pop_front();
                    chk("sb_data", OUT_DATA, mon_e.d);
                    chk("sb_ctrl", 64'(OUT_CTRL), 64'(mon_e.c));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET     = 1'b1;
        FLUSH     = 1'b0;
        BUSYWAIT  = 1'b0;
        OUT_READY = 1'b1;
        IN_VALID  = 1'b1;
        IN_CTRL   = 12'hFFF;
        IN_DATA   = 64'hDEAD;

        // Reset held two cycles with an offered input
        step();
        step();
        status("reset", 1'b0, 1'b1, 2'd0);
        chk("reset_out_ctrl", 64'(OUT_CTRL), 64'h0);
        chk("reset_out_data", OUT_DATA, 64'h0);
        RESET = 1'b0;
        drive(1'b0, 64'h0);
        step();
        status("idle", 1'b0, 1'b1, 2'd0);

        // Streaming 1..5 with OUT_READY=1
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 64'(i));
            expect_item(64'(i));
            step();
            status("stream", 1'b1, 1'b1, 2'd1);
            chk("stream_data", OUT_DATA, 64'(i));
        end
        drive(1'b0, 64'h0);
        step();
        status("stream_end", 1'b0, 1'b1, 2'd0);
        chk("stream_data_hold", OUT_DATA, 64'h5);

        // Skid / backpressure: A, B fill, C waits upstream
        OUT_READY = 1'b0;
        expect_item(64'hA);
        expect_item(64'hB);
        expect_item(64'hC);
        drive(1'b1, 64'hA);
        step();
        status("skid_a", 1'b1, 1'b1, 2'd1);
        drive(1'b1, 64'hB);
        step();
        status("skid_ab", 1'b1, 1'b0, 2'd2);
        chk("skid_head_a", OUT_DATA, 64'hA);
        drive(1'b1, 64'hC);
        step();
        status("skid_c_held", 1'b1, 1'b0, 2'd2);
        step();
        status("skid_c_held2", 1'b1, 1'b0, 2'd2);
        chk("skid_head_a2", OUT_DATA, 64'hA);
        OUT_READY = 1'b1;
        step();
        status("skid_pop_a", 1'b1, 1'b1, 2'd1);
        chk("skid_head_b", OUT_DATA, 64'hB);
        step();
        status("skid_pop_b", 1'b1, 1'b1, 2'd1);
        chk("skid_head_c", OUT_DATA, 64'hC);
        drive(1'b0, 64'h0);
        step();
        status("skid_drained", 1'b0, 1'b1, 2'd0);

        // BUSYWAIT freeze for 3 cycles mid-stream
        drive(1'b1, 64'h21);
        expect_item(64'h21);
        step();
        drive(1'b1, 64'h22);
        expect_item(64'h22);
        BUSYWAIT = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            status("busy", 1'b1, 1'b1, 2'd1);
            chk("busy_data", OUT_DATA, 64'h21);
        end
        BUSYWAIT = 1'b0;
        step();
        chk("busy_resume_22", OUT_DATA, 64'h22);
        drive(1'b1, 64'h23);
        expect_item(64'h23);
        step();
        chk("busy_resume_23", OUT_DATA, 64'h23);
        drive(1'b0, 64'h0);
        step();
        status("busy_drained", 1'b0, 1'b1, 2'd0);

        // Flush at occupancy 2 (entries and flush-cycle input never delivered)
        OUT_READY = 1'b0;
        drive(1'b1, 64'h31);
        step();
        drive(1'b1, 64'h32);
        step();
        status("flush_pre", 1'b1, 1'b0, 2'd2);
        drive(1'b1, 64'h33);
        FLUSH = 1'b1;
        step();
        status("flush", 1'b0, 1'b1, 2'd0);
        chk("flush_ctrl", 64'(OUT_CTRL), 64'h0);
        chk("flush_data_hold", OUT_DATA, 64'h31);
        FLUSH = 1'b0;
        OUT_READY = 1'b1;
        drive(1'b0, 64'h0);
        step();
        status("flush_after", 1'b0, 1'b1, 2'd0);

        // Flush while BUSYWAIT is high
        OUT_READY = 1'b0;
        drive(1'b1, 64'h41);
        step();
        drive(1'b1, 64'h42);
        step();
        status("flushbw_pre", 1'b1, 1'b0, 2'd2);
        drive(1'b1, 64'h43);
        BUSYWAIT = 1'b1;
        FLUSH = 1'b1;
        step();
        status("flushbw", 1'b0, 1'b1, 2'd0);
        chk("flushbw_data_hold", OUT_DATA, 64'h41);
        FLUSH = 1'b0;
        BUSYWAIT = 1'b0;
        OUT_READY = 1'b1;
        drive(1'b0, 64'h0);
        step();
        status("flushbw_after", 1'b0, 1'b1, 2'd0);

        // RESET and FLUSH together: reset wins (OUT_DATA cleared)
        OUT_READY = 1'b0;
        drive(1'b1, 64'h51);
        step();
        status("prio_pre", 1'b1, 1'b1, 2'd1);
        RESET = 1'b1;
        FLUSH = 1'b1;
        drive(1'b1, 64'h52);
        step();
        status("prio_reset", 1'b0, 1'b1, 2'd0);
        chk("prio_reset_data", OUT_DATA, 64'h0);
        RESET = 1'b0;
        OUT_READY = 1'b1;

        // FLUSH with IN_VALID while empty: stays empty
        drive(1'b1, 64'h61);
        step();
        status("flush_empty", 1'b0, 1'b1, 2'd0);
        FLUSH = 1'b0;
        drive(1'b0, 64'h0);
        step();
        status("flush_empty_after", 1'b0, 1'b1, 2'd0);
        step();

        chk("sb_drained", 64'(sb.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid_register.md
Name: pipe_stage_skid_register

Overview:
- Parametrised pipeline stage register; next-generation replacement for the fixed-field inter-stage registers (ID/EX, EX/MEM, MEM/WB).
- Carries a generic control bus and a generic data bus, each with its own width parameter.
- Adds a per-entry valid bit, bubble insertion on flush, a memory BUSYWAIT freeze, and a 2-entry skid buffer. Upstream ready is therefore registered and never combinationally depends on OUT_READY.

Parameters:
- DATA_WIDTH, 64, payload width (e.g. ALU result concatenated with store data).
- CTRL_WIDTH, 12, control width (write enable, mux selects, mem read/write, funct3, rd).
- BUBBLE_CTRL, {CTRL_WIDTH{1'b0}}, value driven on OUT_CTRL whenever OUT_VALID=0 and at reset.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- FLUSH  input  1  synchronous clear of all held entries (branch mispredict / exception).
- BUSYWAIT  input  1  global stall from the data memory/cache; freezes the stage.
- IN_VALID  input  1  upstream has an entry.
- IN_READY  output  1  stage can accept; registered.
- IN_CTRL  input  CTRL_WIDTH  upstream control.
- IN_DATA  input  DATA_WIDTH  upstream payload.
- OUT_VALID  output  1  head entry valid.
- OUT_READY  input  1  downstream consumes head.
- OUT_CTRL  output  CTRL_WIDTH  head control, or BUBBLE_CTRL when not valid.
- OUT_DATA  output  DATA_WIDTH  head payload.
- OCCUPANCY  output  2  number of held entries: 0, 1 or 2.

Behaviour:
- Storage: main entry (drives outputs) and skid entry, each holding a valid bit, control and data.
- Events:
  - accept = IN_VALID & IN_READY & ~BUSYWAIT
  - pop = OUT_VALID & OUT_READY & ~BUSYWAIT
- Priority: RESET > FLUSH > BUSYWAIT > normal operation.
- RESET (sampled at a clock edge):
  - both valids 0; OUT_CTRL = BUBBLE_CTRL; OUT_DATA = 0; skid data/ctrl = 0.
  - IN_READY = 1; OCCUPANCY = 0.
  - An asserted RESET mid-stream discards all held entries; the input in that cycle is not accepted.
- FLUSH (without RESET):
  - next cycle: both valids 0, OCCUPANCY = 0, IN_READY = 1, OUT_CTRL = BUBBLE_CTRL; OUT_DATA holds its last value.
  - Takes effect even while BUSYWAIT = 1.
  - The input presented in the flush cycle is discarded, never accepted.
- BUSYWAIT = 1 (no RESET/FLUSH): no accept, no pop. All registers and outputs hold exactly; IN_READY holds.
- States and transitions:
  - EMPTY (occ 0): accept -> ONE (main <= in); otherwise stay.
  - ONE (occ 1):
    - accept & pop -> ONE (main <= in)
    - accept & ~pop -> TWO (skid <= in)
    - ~accept & pop -> EMPTY
    - otherwise hold.
  - TWO (occ 2): IN_READY = 0, so no accept. pop -> ONE (main <= skid, skid cleared); otherwise hold.
- IN_READY is registered and equals ~skid_valid after each edge; it is 1 in EMPTY/ONE and 0 in TWO.
- Latency and throughput: 1 cycle from accept to OUT_VALID when EMPTY; sustained throughput 1 entry/cycle with OUT_READY = 1.
- Ordering is strictly FIFO; no entry is ever lost or duplicated.
- OUT_CTRL = BUBBLE_CTRL whenever OUT_VALID = 0, so downstream write/memory enables are inactive during bubbles.
- OUT_DATA is don't-care when invalid, but it must hold its last value (no toggling, to save power).
- OCCUPANCY = main_valid + skid_valid.

Test Plan:
- Reset: hold RESET 2 cycles with IN_VALID=1, IN_CTRL=0xFFF -> OUT_VALID=0, OUT_CTRL=BUBBLE_CTRL, OUT_DATA=0, IN_READY=1, OCCUPANCY=0.
- Streaming: OUT_READY=1, push data 0x1..0x5 on consecutive cycles -> same values on OUT_DATA one cycle later, in order; OCCUPANCY stays 1; IN_READY stays 1.
- Skid/backpressure: OUT_READY=0, push A=0xA then B=0xB -> OCCUPANCY=2, IN_READY=0, C=0xC held upstream. Then OUT_READY=1 -> outputs A, B, C in order, no duplicates.
- BUSYWAIT: assert for 3 cycles mid-stream with IN_VALID=1, OUT_READY=1 -> all outputs and OCCUPANCY frozen, nothing accepted. After deassertion the sequence resumes with no gap or loss.
- Flush: at OCCUPANCY=2 with IN_VALID=1, assert FLUSH (also repeat with BUSYWAIT=1) -> next cycle OUT_VALID=0, OUT_CTRL=BUBBLE_CTRL, OCCUPANCY=0, IN_READY=1; the flush-cycle input never appears on the output.
- Priority: RESET and FLUSH together -> OUT_DATA=0 (reset wins); FLUSH with IN_VALID while EMPTY -> remains EMPTY.
